blink_leds_pio: RTL

- Avalon-MM slave output PIO.
- Drives a WIDTH-bit output port (LEDs) from CPU-written registers.
- Provides atomic bit-set and bit-clear, plus a per-bit hardware blink driven by a free-running prescaler.
- Companion to the switch input PIO; sits on the same Nios system interconnect with read latency 1.

---
 rtl/blink_leds_pkg.sv | 17 +
 rtl/blink_leds_pio_prescaler.sv | 51 +++++
 rtl/blink_leds_pio.sv | 130 +++++++++++++
 3 files changed

// File: rtl/blink_leds_pkg.sv
// blink_leds_pkg
// Shared definitions for the blink LED output PIO:
//   - word addresses of the four slave registers
//   - cnt_width(): prescaler counter width for a given blink divider
package blink_leds_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_SET  = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    // Width needed to hold 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/blink_leds_pio_prescaler.sv
// blink_prescaler
// Free-running blink prescaler. Counts 0..BLINK_DIV-1 and toggles the blink
// phase on every wrap. A clear pulse restarts the count and forces phase 0,
// taking priority over a wrap in the same cycle.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   clear  in   restart count and phase
//   phase  out  current blink phase
module blink_prescaler
    import blink_leds_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic phase
);

    localparam int              CW   = cnt_width(BLINK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/blink_leds_pio.sv
// blink_leds_pio
// Avalon-MM slave output PIO driving WIDTH LEDs. Registers (word address):
//   0 DATA       R/W  LED data
//   1 BLINK_MASK R/W  bits that blink; a write restarts the prescaler
//   2 OUTSET     W    data |= wd;   read: live out_port
//   3 OUTCLR     W    data &= ~wd;  read: {31'b0, phase}
// Bus handshake: a write happens at a rising edge where chipselect=1 and
// write_n=0. readdata is re-registered every cycle from the address mux, so
// it is valid one cycle after the address is presented (read latency 1).
// Optional feature macro BLINK_LEDS_BLINK_EN: when undefined there is no
// blink logic, address 1 and 3 read 0, and out_port follows DATA.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   address[1:0]      register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[31:0]   write data (bits at/above WIDTH discarded)
//   readdata[31:0]    registered, zero-extended read data
//   out_port[WIDTH]   registered LED drive
module blink_leds_pio
    import blink_leds_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               BLINK_DIV   = 25000000,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             write_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      rd_q, rd_d;
    logic             unused_wd;

    assign write_en  = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

`ifdef BLINK_LEDS_BLINK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             phase;
    logic             mask_wr;

    assign mask_wr = write_en && (address == ADDR_MASK);

    blink_prescaler #(
        .BLINK_DIV (BLINK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (mask_wr),
        .phase (phase)
    );

    always_comb begin
        mask_d = mask_q;
        if (mask_wr) begin
            mask_d = wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign out_d = data_q ^ (mask_q & {WIDTH{phase}});
`else
    localparam int unused_blink_div = BLINK_DIV;

    assign out_d = data_q;
`endif

    // Exactly one register is touched per write; mask writes are handled above.
    always_comb begin
        data_d = data_q;
        if (write_en) begin
            case (address)
                ADDR_DATA: data_d = wd;
                ADDR_SET:  data_d = data_q | wd;
                ADDR_CLR:  data_d = data_q & ~wd;
                default:   data_d = data_q;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA: rd_d = 32'(data_q);
`ifdef BLINK_LEDS_BLINK_EN
            ADDR_MASK: rd_d = 32'(mask_q);
            ADDR_CLR:  rd_d = {31'b0, phase};
`else
            ADDR_MASK: rd_d = '0;
            ADDR_CLR:  rd_d = '0;
`endif
            ADDR_SET:  rd_d = 32'(out_q);
            default:   rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            out_q  <= RESET_VALUE;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
            rd_q   <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign out_port = out_q;

endmodule
